// File: rtl/sliding_window_conv_param_pkg.sv
// conv_pkg: shared types and helpers for the parametrised sliding-window
// convolution engine.
//   conv_state_t : engine control states
//   out_dim()    : valid-region output size along one dimension
//   cnt_w()      : counter width able to hold 0..n-1 (at least 1 bit)
//   sat_to()     : clamp a wide signed value to a signed data_w-bit range
package conv_pkg;

  typedef enum logic [1:0] {IDLE, LOAD, COMPUTE, DONE} conv_state_t;

  // Widest accumulator sat_to() accepts; callers sign-extend into it.
  localparam int SAT_W = 128;

  function automatic int out_dim(input int img, input int k, input int stride);
    return (img - k) / stride + 1;
  endfunction

  function automatic int cnt_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  function automatic logic signed [SAT_W-1:0] sat_to(input logic signed [SAT_W-1:0] acc,
                                                     input int data_w);
    logic signed [SAT_W-1:0] hi;
    logic signed [SAT_W-1:0] lo;
    hi = (SAT_W'(1) <<< (data_w - 1)) - SAT_W'(1);
    lo = -hi - SAT_W'(1);
    if (acc > hi) return hi;
    if (acc < lo) return lo;
    return acc;
  endfunction

endpackage

// File: rtl/sliding_window_conv_param_if.sv
// Host data-port bundle of the convolution engine.
//   write, kernel_write : pixel / coefficient write strobes (host -> engine)
//   data_in             : signed pixel or coefficient       (host -> engine)
//   read                : result read strobe                (host -> engine)
//   data_out, out_valid : registered result and its valid   (engine -> host)
//   busy, done          : computing / results available     (engine -> host)
interface sliding_window_conv_param_if #(parameter int DATA_W = 32);
  logic                     write;
  logic                     kernel_write;
  logic signed [DATA_W-1:0] data_in;
  logic                     read;
  logic signed [DATA_W-1:0] data_out;
  logic                     out_valid;
  logic                     busy;
  logic                     done;

  modport master (output write, kernel_write, data_in, read,
                  input  data_out, out_valid, busy, done);
  modport slave  (input  write, kernel_write, data_in, read,
                  output data_out, out_valid, busy, done);
endinterface

// File: rtl/sliding_window_conv_param_mac.sv
// conv_mac: two-stage signed multiply-accumulate.
//   clk, reset : rising-edge clock, asynchronous active-low reset
//   en, clr    : tap valid / first tap of a window (restarts the sum)
//   a, b       : signed DATA_W operands
//   acc        : ACC_W running sum, acc_vld marks a freshly updated sum
module conv_mac #(
  parameter int DATA_W = 32,
  parameter int ACC_W  = 2*DATA_W+8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     en,
  input  logic                     clr,
  input  logic signed [DATA_W-1:0] a,
  input  logic signed [DATA_W-1:0] b,
  output logic signed [ACC_W-1:0]  acc,
  output logic                     acc_vld
);
  logic signed [ACC_W-1:0] prod_p1;
  logic signed [ACC_W-1:0] acc_p2;
  logic                    vld_p1;
  logic                    clr_p1;
  logic                    vld_p2;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      vld_p1 <= 1'b0;
      clr_p1 <= 1'b0;
      vld_p2 <= 1'b0;
    end else begin
      vld_p1 <= en;
      clr_p1 <= clr;
      vld_p2 <= vld_p1;
    end
  end

  // Stage p1: operands sign-extended before the multiply
  always_ff @(posedge clk) begin
    if (en) prod_p1 <= ACC_W'(a) * ACC_W'(b);
  end

  // Stage p2: accumulate
  always_ff @(posedge clk) begin
    if (vld_p1) acc_p2 <= clr_p1 ? prod_p1 : acc_p2 + prod_p1;
  end

  assign acc     = acc_p2;
  assign acc_vld = vld_p2;
endmodule

// File: rtl/sliding_window_conv_param.sv
// sliding_window_conv_param: buffers an IMG_H x IMG_W raster image, holds a
// run-time loadable K x K signed kernel, computes the strided valid-region
// convolution one tap per cycle through a shared MAC and streams saturated
// results back on read strobes.
//   clk   : rising-edge clock
//   reset : asynchronous active-low reset
//   bus   : host port (slave side), see sliding_window_conv_param_if
module sliding_window_conv_param
  import conv_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ACC_W  = 2*DATA_W+8,
  parameter int IMG_H  = 5,
  parameter int IMG_W  = 5,
  parameter int K      = 3,
  parameter int STRIDE = 1
) (
  input logic                         clk,
  input logic                         reset,
  sliding_window_conv_param_if.slave  bus
);
  localparam int OUT_H  = out_dim(IMG_H, K, STRIDE);
  localparam int OUT_W  = out_dim(IMG_W, K, STRIDE);
  localparam int N_OUT  = OUT_H * OUT_W;
  localparam int N_PIX  = IMG_H * IMG_W;
  localparam int N_KER  = K * K;
  localparam int N_TAP  = N_OUT * N_KER;
  localparam int CENTRE = (K/2) * K + K/2;

  localparam int PW  = cnt_w(N_PIX);
  localparam int KIW = cnt_w(N_KER);
  localparam int KW  = cnt_w(K);
  localparam int OXW = cnt_w(OUT_W);
  localparam int OYW = cnt_w(OUT_H);
  localparam int CW  = cnt_w(N_TAP + 2);
  localparam int RW  = cnt_w(N_OUT);

  localparam logic [PW-1:0]  PIX_LAST = PW'(N_PIX - 1);
  localparam logic [KIW-1:0] KI_LAST  = KIW'(N_KER - 1);
  localparam logic [KW-1:0]  K_LAST   = KW'(K - 1);
  localparam logic [OXW-1:0] OX_LAST  = OXW'(OUT_W - 1);
  localparam logic [OYW-1:0] OY_LAST  = OYW'(OUT_H - 1);
  localparam logic [CW-1:0]  TAP_N    = CW'(N_TAP);
  localparam logic [CW-1:0]  CYC_LAST = CW'(N_TAP + 1);
  localparam logic [RW-1:0]  RES_LAST = RW'(N_OUT - 1);

  conv_state_t state, state_nxt;

  logic signed [DATA_W-1:0] img     [N_PIX];
  logic signed [DATA_W-1:0] kernel  [N_KER];
  logic signed [DATA_W-1:0] results [N_OUT];

  logic [PW-1:0]  pidx;
  logic [KIW-1:0] kidx;
  logic [KW-1:0]  kx, ky;
  logic [OXW-1:0] ox;
  logic [OYW-1:0] oy;
  logic [CW-1:0]  cyc;
  logic [RW-1:0]  widx, ridx;

  logic pix_we, ker_we, last_pix, compute_end, rd_fire, rd_last, store;
  logic vld_p0, first_p0, last_p0, last_p1, last_p2, acc_vld_p2;
  logic [PW-1:0]  pix_addr;
  logic [KIW-1:0] ker_addr;
  logic signed [DATA_W-1:0] pix_p0, coef_p0;
  logic signed [ACC_W-1:0]  acc_p2;

  always_comb begin
    pix_we      = (state == IDLE || state == LOAD) && bus.write;
    ker_we      = (state == IDLE) && bus.kernel_write && !bus.write;
    last_pix    = pix_we && (pidx == PIX_LAST);
    // Drain: the last tap needs two more edges to land in the accumulator.
    vld_p0      = (state == COMPUTE) && (cyc < TAP_N);
    compute_end = (state == COMPUTE) && (cyc == CYC_LAST);
    rd_fire     = (state == DONE) && bus.read;
    rd_last     = rd_fire && (ridx == RES_LAST);
    first_p0    = (kx == '0) && (ky == '0);
    last_p0     = (kx == K_LAST) && (ky == K_LAST);
    pix_addr    = PW'((int'(oy) * STRIDE + int'(ky)) * IMG_W + int'(ox) * STRIDE + int'(kx));
    ker_addr    = KIW'(int'(ky) * K + int'(kx));
    pix_p0      = img[pix_addr];
    coef_p0     = kernel[ker_addr];
    store       = acc_vld_p2 && last_p2;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, LOAD: if (last_pix) state_nxt = COMPUTE;
                  else if (pix_we) state_nxt = LOAD;
      COMPUTE:    if (compute_end) state_nxt = DONE;
      DONE:       if (rd_last) state_nxt = IDLE;
      default:    state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pidx          <= '0;
      kidx          <= '0;
      kx            <= '0;
      ky            <= '0;
      ox            <= '0;
      oy            <= '0;
      cyc           <= '0;
      widx          <= '0;
      ridx          <= '0;
      last_p1       <= 1'b0;
      last_p2       <= 1'b0;
      bus.busy      <= 1'b0;
      bus.done      <= 1'b0;
      bus.out_valid <= 1'b0;
      bus.data_out  <= '0;
      for (int i = 0; i < N_KER; i++)
        kernel[i] <= (i == CENTRE) ? DATA_W'(1) : '0;
    end else begin
      if (pix_we) pidx <= last_pix ? '0 : pidx + PW'(1);
      if (ker_we) begin
        kernel[kidx] <= bus.data_in;
        kidx         <= (kidx == KI_LAST) ? '0 : kidx + KIW'(1);
      end
      if (state == COMPUTE) cyc <= compute_end ? '0 : cyc + CW'(1);
      // Tap walk: kx fastest, then ky, then output column, then output row.
      if (vld_p0) begin
        if (kx != K_LAST) kx <= kx + KW'(1);
        else begin
          kx <= '0;
          if (ky != K_LAST) ky <= ky + KW'(1);
          else begin
            ky <= '0;
            if (ox != OX_LAST) ox <= ox + OXW'(1);
            else begin
              ox <= '0;
              oy <= (oy == OY_LAST) ? '0 : oy + OYW'(1);
            end
          end
        end
      end
      last_p1 <= vld_p0 && last_p0;
      last_p2 <= last_p1;
      if (store) widx <= (widx == RES_LAST) ? '0 : widx + RW'(1);
      if (rd_fire) begin
        bus.data_out <= results[ridx];
        ridx         <= rd_last ? '0 : ridx + RW'(1);
      end
      bus.out_valid <= rd_fire;
      bus.busy      <= (state_nxt == COMPUTE);
      bus.done      <= (state_nxt == DONE);
    end
  end

  always_ff @(posedge clk) begin
    if (pix_we) img[pidx] <= bus.data_in;
    if (store)  results[widx] <= DATA_W'(sat_to(SAT_W'(acc_p2), DATA_W));
  end

  conv_mac #(.DATA_W(DATA_W), .ACC_W(ACC_W)) u_mac (
    .clk     (clk),
    .reset   (reset),
    .en      (vld_p0),
    .clr     (first_p0),
    .a       (pix_p0),
    .b       (coef_p0),
    .acc     (acc_p2),
    .acc_vld (acc_vld_p2)
  );
endmodule

// File: tb/tb_sliding_window_conv_param.sv
// Directed bench for sliding_window_conv_param: three instances (defaults,
// STRIDE=2, DATA_W=8) share one stimulus stream; `sel` picks the instance
// whose outputs are scored against the expected-result queue.
module tb_sliding_window_conv_param;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset;
  logic write, kernel_write, read;
  logic signed [31:0] din;

  sliding_window_conv_param_if #(.DATA_W(32)) if_a ();
  sliding_window_conv_param_if #(.DATA_W(32)) if_s2 ();
  sliding_window_conv_param_if #(.DATA_W(8))  if_w8 ();

  assign if_a.write  = write;  assign if_a.kernel_write  = kernel_write;
  assign if_a.read   = read;   assign if_a.data_in       = din;
  assign if_s2.write = write;  assign if_s2.kernel_write = kernel_write;
  assign if_s2.read  = read;   assign if_s2.data_in      = din;
  assign if_w8.write = write;  assign if_w8.kernel_write = kernel_write;
  assign if_w8.read  = read;   assign if_w8.data_in      = din[7:0];

  sliding_window_conv_param #(.DATA_W(32), .IMG_H(5), .IMG_W(5), .K(3), .STRIDE(1))
    dut_a  (.clk(clk), .reset(reset), .bus(if_a));
  sliding_window_conv_param #(.DATA_W(32), .IMG_H(5), .IMG_W(5), .K(3), .STRIDE(2))
    dut_s2 (.clk(clk), .reset(reset), .bus(if_s2));
  sliding_window_conv_param #(.DATA_W(8), .IMG_H(5), .IMG_W(5), .K(3), .STRIDE(1))
    dut_w8 (.clk(clk), .reset(reset), .bus(if_w8));

  int sel;
  logic signed [31:0] obs_do;
  logic obs_ov, obs_busy, obs_done;

  always_comb begin
    obs_do = if_a.data_out; obs_ov = if_a.out_valid;
    obs_busy = if_a.busy;   obs_done = if_a.done;
    if (sel == 1) begin
      obs_do = if_s2.data_out; obs_ov = if_s2.out_valid;
      obs_busy = if_s2.busy;   obs_done = if_s2.done;
    end else if (sel == 2) begin
      obs_do = 32'(if_w8.data_out); obs_ov = if_w8.out_valid;
      obs_busy = if_w8.busy;        obs_done = if_w8.done;
    end
  end

  logic signed [31:0] exp_q[$];
  int n_assert = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic signed [31:0] obs,
                       input logic signed [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic push_list(input int v0, input int v1, input int v2, input int v3,
                           input int v4, input int v5, input int v6, input int v7,
                           input int v8, input int n);
    int v[9];
    v = '{v0, v1, v2, v3, v4, v5, v6, v7, v8};
    for (int i = 0; i < n; i++) exp_q.push_back(v[i]);
  endtask

  // Pixel i = base + inc*i, with a one-cycle write gap before pixel 12.
  task automatic write_frame(input int base, input int inc, input bit collide);
    for (int i = 0; i < 25; i++) begin
      if (i == 12) begin
        @(negedge clk); write = 1'b0; kernel_write = 1'b0;
      end
      @(negedge clk);
      write = 1'b1; din = base + inc * i;
      kernel_write = collide && (i == 0);
    end
    @(negedge clk); write = 1'b0; kernel_write = 1'b0;
  endtask

  // Entered on the negedge right after the last-pixel edge.
  task automatic wait_done(input int exp_cyc, input int poke);
    int cnt;
    cnt = 0;
    check("busy_after_load", obs_busy, 1);
    while (!obs_done && cnt < 400) begin
      @(negedge clk);
      cnt++;
      write = (cnt == poke); kernel_write = (cnt == poke); din = 99;
    end
    write = 1'b0; kernel_write = 1'b0;
    if (exp_cyc > 0) check("done_latency", cnt, exp_cyc);
    else             check("done_seen", obs_done, 1);
    check("busy_at_done", obs_busy, 0);
  endtask

  task automatic read_results(input int n);
    logic signed [31:0] e;
    for (int i = 0; i < n; i++) begin
      @(negedge clk); read = 1'b1;
      @(negedge clk); read = 1'b0;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("out_valid", obs_ov, 1);
        check("data_out", obs_do, e);
        if (exp_q.size() == 0) check("done_fall", obs_done, 0);
      end else begin
        check("extra_read_valid", obs_ov, 0);
      end
    end
    @(negedge clk);
    check("idle_valid", obs_ov, 0);
  endtask

  task automatic drain();
    repeat (60) @(negedge clk);
    for (int i = 0; i < 9; i++) begin
      @(negedge clk); read = 1'b1;
      @(negedge clk); read = 1'b0;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    write = 1'b0; kernel_write = 1'b0; read = 1'b0; din = '0; sel = 0;
    reset = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_data_out", obs_do, 0);
    check("rst_out_valid", obs_ov, 0);
    check("rst_busy", obs_busy, 0);
    check("rst_done", obs_done, 0);
    reset = 1'b1;
    @(negedge clk);

    // Identity kernel after reset
    push_list(6, 7, 8, 11, 12, 13, 16, 17, 18, 9);
    write_frame(0, 1, 1'b0);
    wait_done(83, -1);
    read_results(9);

    // All-ones kernel loaded into every instance
    for (int i = 0; i < 9; i++) begin
      @(negedge clk); kernel_write = 1'b1; din = 1;
    end
    @(negedge clk); kernel_write = 1'b0;
    push_list(54, 63, 72, 99, 108, 117, 144, 153, 162, 9);
    write_frame(0, 1, 1'b0);
    wait_done(83, -1);
    read_results(10);

    // STRIDE=2 instance
    sel = 1;
    push_list(54, 72, 144, 162, 0, 0, 0, 0, 0, 4);
    write_frame(0, 1, 1'b0);
    wait_done(38, -1);
    read_results(5);
    sel = 0;
    drain();

    // DATA_W=8 saturation, both rails
    sel = 2;
    push_list(127, 127, 127, 127, 127, 127, 127, 127, 127, 9);
    write_frame(127, 0, 1'b0);
    wait_done(83, -1);
    read_results(9);
    push_list(-128, -128, -128, -128, -128, -128, -128, -128, -128, 9);
    write_frame(-128, 0, 1'b0);
    wait_done(83, -1);
    read_results(9);

    // Reset 10 cycles into COMPUTE
    sel = 0;
    write_frame(0, 1, 1'b0);
    repeat (10) @(negedge clk);
    check("mid_busy", obs_busy, 1);
    reset = 1'b0;
    #1;
    check("abort_data_out", obs_do, 0);
    check("abort_out_valid", obs_ov, 0);
    check("abort_busy", obs_busy, 0);
    check("abort_done", obs_done, 0);
    @(negedge clk); reset = 1'b1;
    push_list(6, 7, 8, 11, 12, 13, 16, 17, 18, 9);
    write_frame(0, 1, 1'b0);
    wait_done(83, -1);
    read_results(9);

    // Simultaneous strobes in IDLE, and strobes poked during COMPUTE
    push_list(11, 12, 13, 16, 17, 18, 21, 22, 23, 9);
    write_frame(5, 1, 1'b1);
    wait_done(83, 5);
    read_results(9);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule

// File: doc/sliding_window_conv_param.md
Name: sliding_window_conv_param

Overview:
Parametrised successor to the fixed 5x5/3x3 sliding-window convolution engine. The block:
- buffers an IMG_H x IMG_W input image written in raster order;
- holds a run-time loadable K x K signed kernel;
- computes a strided valid-region convolution with one shared MAC;
- streams results out through the same write/read/done handshake style as the existing engine.

It sits behind the host data port as a standalone accelerator.

Parameters:
DATA_W, 32, signed pixel/kernel/result width
ACC_W, 2*DATA_W+8, internal accumulator width
IMG_H, 5, input rows
IMG_W, 5, input columns
K, 3, kernel size (K <= IMG_H, K <= IMG_W)
STRIDE, 1, window step in both dimensions (>=1)

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-low reset
write  in  1  pixel write strobe
kernel_write  in  1  kernel coefficient write strobe
data_in  in  DATA_W  signed pixel or coefficient
read  in  1  result read strobe
data_out  out  DATA_W  signed result, registered
out_valid  out  1  data_out valid this cycle
busy  out  1  computing
done  out  1  results available

Behaviour:
- Derived sizes: OUT_H=(IMG_H-K)/STRIDE+1, OUT_W=(IMG_W-K)/STRIDE+1, N_OUT=OUT_H*OUT_W.
- Reset (reset=0, async):
  - state=IDLE; all counters 0.
  - data_out=0, out_valid=0, busy=0, done=0.
  - Kernel reverts to identity: centre coefficient [K/2][K/2]=1, all others 0.
  - Image buffer contents are don't-care.
- States: IDLE, LOAD, COMPUTE, DONE.
- IDLE:
  - kernel_write=1 (with write=0) stores data_in at kernel index kidx, raster order; kidx wraps K*K-1 -> 0.
  - write=1 stores pixel 0, goes to LOAD.
  - write has priority: if both strobes are high, kernel_write is dropped.
- LOAD:
  - Each write=1 edge stores the next pixel in raster order. Gaps (write=0) are allowed.
  - kernel_write is ignored.
  - After pixel IMG_H*IMG_W-1 is stored, go to COMPUTE; busy=1 the next cycle.
- COMPUTE:
  - Windows are processed in raster order (row-major over output positions); taps within a window also in raster order.
  - One tap per cycle through the MAC: pipeline of multiply register, then accumulate.
  - Result stored after the final tap of each window.
  - Total: N_OUT*K*K tap cycles plus 2 drain cycles.
  - done rises exactly N_OUT*K*K+2 cycles after the edge that stored the last pixel; busy falls on the same edge.
  - write, kernel_write and read are ignored.
- Arithmetic:
  - Signed products are sign-extended to ACC_W and summed.
  - Each result saturates to the signed DATA_W range: max 2^(DATA_W-1)-1, min -2^(DATA_W-1).
- DONE:
  - Each edge with read=1: data_out <= result[ridx], out_valid=1, ridx++.
  - read=0: out_valid=0, data_out holds its last value.
  - On the edge that outputs result N_OUT-1, done falls and state goes to IDLE; further reads give out_valid=0.
  - write in DONE is ignored.
- The kernel persists across frames until reset or reload.
- Reset asserted mid-LOAD, mid-COMPUTE or mid-read aborts immediately to reset values; no partial result is emitted.

Decomposition:
- Package conv_pkg holds:
  - the state enum conv_state_t;
  - function out_dim(img, k, stride);
  - the saturate function sat_to(acc, DATA_W).
- Sub-module conv_mac: 2-stage signed multiply-accumulate with clear and enable, parametrised DATA_W/ACC_W, same clock and reset.

Test Plan:
- Defaults, no kernel load, input 0..24 raster, read 9 -> outputs 6 7 8 11 12 13 16 17 18; done rises 83 cycles after last write.
- Load 9 ones, same input -> 54 63 72 99 108 117 144 153 162; done falls on the 9th read edge, a 10th read gives out_valid=0.
- STRIDE=2, all-ones kernel, same input -> 4 outputs: 54 72 144 162.
- DATA_W=8, all-ones kernel:
  - all pixels 127 -> every output 127 (sum 1143 saturated);
  - all pixels -128 -> every output -128.
- Reset pulsed 10 cycles into COMPUTE -> all outputs 0 immediately, kernel back to identity; a fresh 0..24 frame then yields the identity results.
- write and kernel_write high together in IDLE -> pixel stored, kernel unchanged; a write pulse during COMPUTE -> ignored, results unchanged.
